// File: rtl/axis_pixel_streamer.sv
// Frame buffer plus AXI-Stream transmitter: holds NUM_PIXELS pixels and streams them with backpressure.
// Optional feature macro AXIS_LOOP_EN adds loop_mode for back-to-back repeated frames.
module axis_pixel_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
`ifdef AXIS_LOOP_EN
  input  logic                  loop_mode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] axis_out_data,
  output logic                  axis_out_valid,
  input  logic                  axis_out_ready,
  output logic                  axis_out_last
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_PIXELS - 1);
  localparam logic [PTR_W-1:0] END_IDX  = PTR_W'(NUM_PIXELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_en;
  logic                  rd_vld;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  skid_last;

  logic       pop;
  logic       final_hs;
  logic       loop_on;
  logic       flush;
  logic       wr_accept;
  logic       room;
  logic [1:0] occupancy;

`ifdef AXIS_LOOP_EN
  assign loop_on = loop_mode;
`else
  assign loop_on = 1'b0;
`endif

  assign pop      = axis_out_valid & axis_out_ready;
  assign final_hs = (state == STREAM) && pop && axis_out_last;

  // Room is judged against output reg + skid reg + the read still in flight.
  assign occupancy = 2'(axis_out_valid) + 2'(skid_valid) + 2'(rd_vld);
  assign room      = (occupancy < 2'd2) || (pop && (occupancy == 2'd2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (final_hs && !loop_on) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    rd_en     = 1'b0;
    wr_accept = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE:    wr_accept = wr_en && ({1'b0, wr_addr} < END_IDX);
      STREAM: begin
        rd_en = (rd_ptr != END_IDX) && room;
        flush = final_hs && !loop_on;
      end
      default: ;
    endcase
  end

  // NOTE: the pixel array is deliberately not reset, so frames survive s_axi_aresetn and it maps to block RAM.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_accept) mem[wr_addr] <= wr_data;
    if (rd_en)     rd_data      <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        rd_ptr <= '0;
      end else if (final_hs && loop_on && rd_ptr == END_IDX) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        // In loop mode the read-ahead wraps so the next frame follows without a bubble.
        rd_ptr <= (rd_ptr == LAST_IDX && loop_on) ? '0 : rd_ptr + PTR_W'(1);
      end
      rd_vld <= rd_en && !flush;
      if (rd_en) rd_last <= (rd_ptr == LAST_IDX);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      axis_out_valid <= 1'b0;
      axis_out_last  <= 1'b0;
      axis_out_data  <= '0;
      skid_valid     <= 1'b0;
      skid_last      <= 1'b0;
      skid_data      <= '0;
    end else if (flush) begin
      // Frame ended without looping: drop any beats prefetched for a next frame.
      axis_out_valid <= 1'b0;
      axis_out_last  <= 1'b0;
      skid_valid     <= 1'b0;
    end else if (!axis_out_valid || axis_out_ready) begin
      if (skid_valid) begin
        axis_out_valid <= 1'b1;
        axis_out_data  <= skid_data;
        axis_out_last  <= skid_last;
        skid_valid     <= rd_vld;
        skid_data      <= rd_data;
        skid_last      <= rd_last;
      end else begin
        axis_out_valid <= rd_vld;
        if (rd_vld) begin
          axis_out_data <= rd_data;
          axis_out_last <= rd_last;
        end
      end
    end else if (rd_vld) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_data;
      skid_last  <= rd_last;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= final_hs;
      busy <= (state == STREAM) && !flush;
    end
  end

endmodule

// File: tb/tb_axis_pixel_streamer.sv
// Bench for axis_pixel_streamer: frame-level model of the expected beat stream, checked every cycle.
// Define AXIS_LOOP_EN for both bench and RTL to exercise loop_mode.
module tb_axis_pixel_streamer;

  localparam int DW = 16;
  localparam int NP = 784;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;
  logic          loop_drv = 1'b0;

  always #5 clk = ~clk;

  axis_pixel_streamer #(.DATA_WIDTH(DW), .NUM_PIXELS(NP), .ADDR_WIDTH(AW)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rstn),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .start          (start),
`ifdef AXIS_LOOP_EN
    .loop_mode      (loop_drv),
`endif
    .busy           (busy),
    .done           (done),
    .axis_out_data  (data),
    .axis_out_valid (valid),
    .axis_out_ready (ready),
    .axis_out_last  (last)
  );

  int checks   = 0;
  int failures = 0;

  // Model: the pixel buffer as the spec says it must look, and where in a frame the stream is.
  int            model_mem [NP];
  logic [DW-1:0] cap [NP];
  int            idx = 0;
  int            hs_count = 0;
  int            last_count = 0;
  int            done_count = 0;
  int            cyc = 0;
  int            first_target = -1;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [DW-1:0] first_data = '0;
  bit            pending = 0;
  bit            frame_ends = 1;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            frame_active = 0;
  int            ready_mode = 0;
  int            b_hs, b_done, b_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs sampled on the falling edge, handshake decided for the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn !== 1'b1) begin
        idx       = 0;
        pending   = 0;
        prev_hold = 0;
      end else begin
        check("done_timing", 32'(done), 32'(pending));
        if (pending) check("busy_at_done", 32'(busy), 32'(!frame_ends));
        pending = 0;
        if (prev_hold) begin
          check("hold_valid", 32'(valid), 32'd1);
          check("hold_data", 32'(data), 32'(prev_data));
          check("hold_last", 32'(last), 32'(prev_last));
        end
        if (valid === 1'b1 && ready === 1'b1) begin
          if (hs_count == first_target) begin
            first_cyc  = cyc;
            first_data = data;
          end
          check("beat_data", 32'(data), model_mem[idx]);
          check("beat_last", 32'(last), 32'(idx == NP - 1));
          cap[idx] = data;
          hs_count++;
          if (last) last_count++;
          if (idx == NP - 1) begin
            check("busy_at_last", 32'(busy), 32'd1);
            pending    = 1;
            frame_ends = !loop_drv;
            last_cyc   = cyc;
            idx        = 0;
          end else begin
            idx++;
          end
        end
        prev_hold = (valid === 1'b1) && (ready !== 1'b1);
        prev_data = data;
        prev_last = last;
        if (done === 1'b1) done_count++;
      end
    end
  end

  // Sink ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    int pat;
    pat   = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ready = (pat % 4 == 0) || (pat % 4 == 3);
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      pat++;
    end
  end

  task automatic write_px(input int a, input int d);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    if (!frame_active && a < NP) model_mem[a] = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic begin_frame(input int mode);
    ready_mode   = mode;
    frame_active = 1;
    b_hs         = hs_count;
    b_done       = done_count;
    b_last       = last_count;
    first_target = hs_count;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done_count(input int target);
    int c;
    c = 0;
    while (done_count < target && c < 20000) begin
      @(posedge clk);
      c++;
    end
    check("done_timeout", 32'(done_count >= target), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (hs_count - b_hs < n && c < 20000) begin
      @(posedge clk);
      c++;
    end
    check("beat_timeout", 32'(hs_count - b_hs >= n), 32'd1);
  endtask

  task automatic finish_frame(input int frames);
    wait_done_count(b_done + frames);
    repeat (5) @(posedge clk);
    #1;
    check("beat_total", 32'(hs_count - b_hs), 32'(frames * NP));
    check("done_total", 32'(done_count - b_done), 32'(frames));
    check("last_total", 32'(last_count - b_last), 32'(frames));
    check("busy_after", 32'(busy), 32'd0);
    frame_active = 0;
    ready_mode   = 0;
  endtask

  initial begin
    rstn    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    for (int i = 0; i < NP; i++) model_mem[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < NP; i++) write_px(i, i + 1);
    write_px(800, 16'hBEEF);

    // Frame 1: full rate, with start-to-valid latency pinned by hand.
    begin_frame(0);
    check("lat_busy_n", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("lat_busy_n1", 32'(busy), 32'd1);
    check("lat_valid_n1", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid_n2", 32'(valid), 32'd1);
    check("lat_data_n2", 32'(data), 32'd1);
    finish_frame(1);
    check("f1_first", 32'(cap[0]), 32'd1);
    check("f1_final", 32'(cap[NP-1]), 32'd784);
    check("f1_rate", 32'(last_cyc - first_cyc), 32'd783);

    // Frame 2: ready 1,0,0,1 and a write attempted while busy.
    begin_frame(1);
    repeat (20) @(posedge clk);
    write_px(5, 16'hBEEF);
    finish_frame(1);

    // Frame 3: random ready; beat 5 must still carry the original pixel.
    begin_frame(2);
    finish_frame(1);
    check("beat5_kept", 32'(cap[5]), 32'd6);

    // Frame 4: start pulsed mid-frame is ignored.
    begin_frame(0);
    wait_beats(100);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_frame(1);
    repeat (30) @(posedge clk);
    #1;
    check("no_requeue_beats", 32'(hs_count - b_hs), 32'(NP));
    check("no_requeue_done", 32'(done_count - b_done), 32'd1);

    // Frame 5: reset at beat 300 abandons the frame silently.
    begin_frame(0);
    wait_beats(300);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_last", 32'(last), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_nodone", 32'(done_count - b_done), 32'd0);
    frame_active = 0;

    // Frame 6: after reset the stream restarts at pixel 0.
    begin_frame(1);
    finish_frame(1);
    check("post_rst_first", 32'(first_data), 32'd1);

`ifdef AXIS_LOOP_EN
    // Loop: two looped frames then one final frame, all back-to-back.
    loop_drv = 1'b1;
    begin_frame(0);
    wait_done_count(b_done + 2);
    loop_drv = 1'b0;
    finish_frame(3);
    check("loop_rate", 32'(last_cyc - first_cyc), 32'd2351);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
